// File: rtl/motor_poll_scheduler.sv
// Round scheduler for per-motor UART exchanges: a phase accumulator ticks rounds, and each round
// walks the enabled motors, requesting CONFIG or SETPOINT frames with timeout/CRC retries.
module motor_poll_scheduler #(
  parameter int unsigned NUMBER_OF_MOTORS = 8,
  parameter int unsigned CLOCK_FREQ_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES   = 5000,
  parameter int unsigned MAX_RETRIES      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 update_frequency_Hz,
  input  logic [NUMBER_OF_MOTORS-1:0] enable_mask,
  input  logic [NUMBER_OF_MOTORS-1:0] cfg_dirty,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [7:0]                  req_motor,
  output logic [1:0]                  req_kind,
  input  logic                        resp_valid,
  input  logic [7:0]                  resp_motor,
  input  logic                        resp_crc_ok,
  output logic                        done_valid,
  output logic [7:0]                  done_motor,
  output logic [1:0]                  done_status,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned N    = NUMBER_OF_MOTORS;
  localparam int unsigned IdxW = $clog2(N + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] KindSet = 2'd1;
  localparam logic [1:0] KindCfg = 2'd2;
  localparam logic [1:0] StatOk  = 2'd0;
  localparam logic [1:0] StatCrc = 2'd1;
  localparam logic [1:0] StatTmo = 2'd2;

  typedef enum logic [1:0] {StIdle, StScan, StReq, StWait} state_e;

  state_e            r_state, w_state_d;
  logic [31:0]       r_acc, w_acc_d;
  logic [N-1:0]      r_round_mask, w_round_mask_d;
  logic [N-1:0]      r_cfg_pending, w_cfg_pending_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic [1:0]        r_kind, w_kind_d;
  logic [2:0]        r_retries, w_retries_d;
  logic [TmrW-1:0]   r_timer, w_timer_d;

  logic [31:0]       w_freq;
  logic [32:0]       w_sum;
  logic              w_tick;
  logic [N:0]        w_mask_ext, w_pend_ext;
  logic              w_resp_hit, w_timeout, w_attempt_end, w_last, w_clr_cfg;
  logic [1:0]        w_status;

  // Clamp the rate so the accumulator can wrap at most once per cycle.
  assign w_freq  = (update_frequency_Hz > CLOCK_FREQ_HZ) ? CLOCK_FREQ_HZ : update_frequency_Hz;
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_freq};
  assign w_tick  = (w_freq != 32'd0) && (w_sum >= 33'(CLOCK_FREQ_HZ));
  // Result is below CLOCK_FREQ_HZ, so 32-bit modular arithmetic is exact.
  assign w_acc_d = r_acc + w_freq - (w_tick ? CLOCK_FREQ_HZ : 32'd0);

  // Padded by one bit so an index equal to N is a legal (zero) select.
  assign w_mask_ext = {1'b0, r_round_mask};
  assign w_pend_ext = {1'b0, r_cfg_pending};

  assign w_resp_hit    = resp_valid && (resp_motor == 8'(r_idx));
  assign w_timeout     = (r_timer == TmrW'(TIMEOUT_CYCLES - 1));
  assign w_attempt_end = (r_state == StWait) && (w_resp_hit || w_timeout);
  assign w_status      = w_resp_hit ? (resp_crc_ok ? StatOk : StatCrc) : StatTmo;
  assign w_last        = (w_status == StatOk) || (r_retries == 3'(MAX_RETRIES));
  assign w_clr_cfg     = (r_state == StWait) && w_resp_hit && resp_crc_ok && (r_kind == KindCfg);

  always_comb begin
    w_state_d      = r_state;
    w_idx_d        = r_idx;
    w_kind_d       = r_kind;
    w_retries_d    = r_retries;
    w_timer_d      = r_timer;
    w_round_mask_d = r_round_mask;
    req_valid      = 1'b0;
    done_valid     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_tick) begin
          w_round_mask_d = enable_mask;
          w_idx_d        = '0;
          w_state_d      = StScan;
        end
      end
      StScan: begin
        if (r_idx == IdxW'(N)) begin
          w_state_d = StIdle;
        end else if (w_mask_ext[r_idx]) begin
          w_kind_d    = w_pend_ext[r_idx] ? KindCfg : KindSet;
          w_retries_d = 3'd0;
          w_state_d   = StReq;
        end else begin
          w_idx_d = r_idx + IdxW'(1);
        end
      end
      StReq: begin
        req_valid = 1'b1;
        if (req_ready) begin
          w_timer_d = '0;
          w_state_d = StWait;
        end
      end
      StWait: begin
        w_timer_d = r_timer + TmrW'(1);
        if (w_attempt_end) begin
          if (w_last) begin
            done_valid = 1'b1;
            w_idx_d    = r_idx + IdxW'(1);
            w_state_d  = StScan;
          end else begin
            w_retries_d = r_retries + 3'd1;
            w_state_d   = StReq;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // A new cfg_dirty pulse overrides a same-cycle clear.
  always_comb begin
    w_cfg_pending_d = r_cfg_pending;
    for (int i = 0; i < int'(N); i++) begin
      w_cfg_pending_d[i] = cfg_dirty[i] |
                           (r_cfg_pending[i] & ~(w_clr_cfg && (r_idx == IdxW'(i))));
    end
  end

  assign req_motor   = req_valid ? 8'(r_idx) : 8'd0;
  assign req_kind    = req_valid ? r_kind : 2'd0;
  assign done_motor  = done_valid ? 8'(r_idx) : 8'd0;
  assign done_status = done_valid ? w_status : 2'd0;
  assign busy        = (r_state != StIdle);
  assign overrun     = w_tick && busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_acc         <= '0;
      r_round_mask  <= '0;
      r_cfg_pending <= '1;
      r_idx         <= '0;
      r_kind        <= '0;
      r_retries     <= '0;
      r_timer       <= '0;
    end else begin
      r_state       <= w_state_d;
      r_acc         <= w_acc_d;
      r_round_mask  <= w_round_mask_d;
      r_cfg_pending <= w_cfg_pending_d;
      r_idx         <= w_idx_d;
      r_kind        <= w_kind_d;
      r_retries     <= w_retries_d;
      r_timer       <= w_timer_d;
    end
  end

endmodule

// File: tb/tb_motor_poll_scheduler.sv
// Bench for motor_poll_scheduler: directed round scenarios with literal event timings, then
// randomized traffic checked every cycle against a motor-level round model.
module tb_motor_poll_scheduler;

  localparam int unsigned N   = 8;
  localparam int unsigned CLK = 50_000_000;
  localparam int unsigned TMO = 100;
  localparam int unsigned MR  = 2;

  localparam int PhIdle = 0, PhGap = 1, PhReq = 2, PhWait = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  update_frequency_Hz;
  logic [N-1:0] enable_mask, cfg_dirty;
  logic         req_valid, req_ready, resp_valid, resp_crc_ok, done_valid, busy, overrun;
  logic [7:0]   req_motor, resp_motor, done_motor;
  logic [1:0]   req_kind, done_status;

  motor_poll_scheduler #(
    .NUMBER_OF_MOTORS(N), .CLOCK_FREQ_HZ(CLK), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MR)
  ) u_dut (
    .clk(clk), .reset(reset), .update_frequency_Hz(update_frequency_Hz),
    .enable_mask(enable_mask), .cfg_dirty(cfg_dirty), .req_valid(req_valid),
    .req_ready(req_ready), .req_motor(req_motor), .req_kind(req_kind),
    .resp_valid(resp_valid), .resp_motor(resp_motor), .resp_crc_ok(resp_crc_ok),
    .done_valid(done_valid), .done_motor(done_motor), .done_status(done_status),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round model: motor-level view (which motor, which attempt, cycles until next request).
  longint       m_acc;
  int           m_phase, m_gap, m_target, m_motor, m_kind, m_attempt, m_wait;
  bit [N-1:0]   m_mask, m_pend;

  // Event log from the DUT for literal timing checks.
  int ev_cyc[$], ev_type[$], ev_motor[$], ev_val[$];

  // Scanning from motor p costs one cycle per index visited up to the first enabled one.
  function automatic void scan_from(input int p);
    m_target = -1;
    for (int j = N - 1; j >= p; j--) if (m_mask[j]) m_target = j;
    m_gap   = (m_target >= 0) ? (m_target - p + 1) : (N - p + 1);
    m_phase = PhGap;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      m_acc = 0; m_phase = PhIdle; m_pend = '1; m_mask = '0; m_motor = 0; cyc = 0;
      ev_cyc.delete(); ev_type.delete(); ev_motor.delete(); ev_val.delete();
      chk("rst_req_valid", req_valid, 0);   chk("rst_req_motor", req_motor, 0);
      chk("rst_req_kind", req_kind, 0);     chk("rst_done_valid", done_valid, 0);
      chk("rst_done_motor", done_motor, 0); chk("rst_done_status", done_status, 0);
      chk("rst_busy", busy, 0);             chk("rst_overrun", overrun, 0);
    end else begin
      longint f;
      bit tick, hit, tmo, fin, clr;
      int st;
      f    = (update_frequency_Hz > CLK) ? CLK : update_frequency_Hz;
      tick = (f != 0) && (m_acc + f >= CLK);
      hit  = (m_phase == PhWait) && resp_valid && (resp_motor == 8'(m_motor));
      tmo  = (m_phase == PhWait) && !hit && (m_wait == TMO - 1);
      st   = hit ? (resp_crc_ok ? 0 : 1) : 2;
      fin  = (hit || tmo) && (st == 0 || m_attempt == MR);
      clr  = hit && resp_crc_ok && (m_kind == 2);

      chk("busy", busy, m_phase != PhIdle);
      chk("overrun", overrun, tick && (m_phase != PhIdle));
      chk("req_valid", req_valid, m_phase == PhReq);
      chk("done_valid", done_valid, fin);
      if (req_valid && m_phase == PhReq) begin
        chk("req_motor", req_motor, m_motor);
        chk("req_kind", req_kind, m_kind);
      end
      if (done_valid && fin) begin
        chk("done_motor", done_motor, m_motor);
        chk("done_status", done_status, st);
      end

      if (req_valid && req_ready) begin
        ev_cyc.push_back(cyc); ev_type.push_back(0);
        ev_motor.push_back(req_motor); ev_val.push_back(req_kind);
      end
      if (done_valid) begin
        ev_cyc.push_back(cyc); ev_type.push_back(1);
        ev_motor.push_back(done_motor); ev_val.push_back(done_status);
      end

      case (m_phase)
        PhIdle: if (tick) begin m_mask = enable_mask; scan_from(0); end
        PhGap: begin
          m_gap--;
          if (m_gap == 0) begin
            if (m_target < 0) m_phase = PhIdle;
            else begin
              m_motor = m_target; m_kind = m_pend[m_target] ? 2 : 1;
              m_attempt = 0; m_phase = PhReq;
            end
          end
        end
        PhReq: if (req_ready) begin m_phase = PhWait; m_wait = 0; end
        default: begin
          if (hit || tmo) begin
            if (fin) scan_from(m_motor + 1);
            else begin m_attempt++; m_phase = PhReq; end
          end else m_wait++;
        end
      endcase
      if (clr) m_pend[m_motor] = 1'b0;
      m_pend = m_pend | cfg_dirty;
      m_acc  = tick ? (m_acc + f - CLK) : (m_acc + f);
      cyc++;
    end
  end

  // Stimulus knobs.
  int p_ready, p_resp, p_wrong, p_crc_bad, p_dirty, silent;
  bit instant, mask_jitter;

  task automatic drive();
    req_ready = ($urandom_range(99) < p_ready);
    cfg_dirty = '0;
    for (int i = 0; i < N; i++) if ($urandom_range(99) < p_dirty) cfg_dirty[i] = 1'b1;
    if (mask_jitter && $urandom_range(199) == 0) enable_mask = N'($urandom);
    resp_motor  = 8'(m_motor);
    resp_crc_ok = 1'b1;
    if (instant) begin
      resp_valid = (m_phase == PhWait) && (m_motor != silent);
    end else begin
      if ($urandom_range(99) < p_wrong) resp_motor = 8'($urandom_range(N - 1));
      resp_valid  = ($urandom_range(99) < p_resp) && (resp_motor != 8'(silent));
      resp_crc_ok = ($urandom_range(99) >= p_crc_bad);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; drive(); end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive();
  endtask

  task automatic set_directed(input logic [N-1:0] mask, input int sil);
    update_frequency_Hz = 32'd1_000_000; enable_mask = mask;
    p_ready = 100; p_dirty = 0; instant = 1'b1; silent = sil; mask_jitter = 1'b0;
  endtask

  task automatic check_ev(input int k, input int c, input int t, input int m, input int v);
    chk("ev_present", k < ev_cyc.size(), 1);
    if (k < ev_cyc.size()) begin
      chk($sformatf("ev%0d_cycle", k), ev_cyc[k], c);
      chk($sformatf("ev%0d_type", k), ev_type[k], t);
      chk($sformatf("ev%0d_motor", k), ev_motor[k], m);
      chk($sformatf("ev%0d_value", k), ev_val[k], v);
    end
  endtask

  initial begin
    update_frequency_Hz = '0; enable_mask = '0; cfg_dirty = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_motor = '0; resp_crc_ok = 1'b0;
    p_ready = 100; p_resp = 0; p_wrong = 0; p_crc_bad = 0; p_dirty = 0;
    silent = -1; instant = 1'b1; mask_jitter = 1'b0;

    // All motors, 50-cycle rounds: first round CONFIG, second SETPOINT, 3 cycles per motor.
    set_directed(8'hFF, -1);
    do_reset();
    run_cycles(130);
    chk("r12_event_count", ev_cyc.size(), 32);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        check_ev((r * 8 + i) * 2,     51 + 50 * r + 3 * i, 0, i, (r == 0) ? 2 : 1);
        check_ev((r * 8 + i) * 2 + 1, 52 + 50 * r + 3 * i, 1, i, 0);
      end

    // Sparse mask: motor 2 requested 3 cycles after motor 0 completes.
    set_directed(8'h05, -1);
    do_reset();
    run_cycles(70);
    chk("sparse_event_count", ev_cyc.size(), 4);
    check_ev(0, 51, 0, 0, 2); check_ev(1, 52, 1, 0, 0);
    check_ev(2, 55, 0, 2, 2); check_ev(3, 56, 1, 2, 0);

    // Silent motor 3: three attempts 101 cycles apart, TIMEOUT status, then motor 4.
    set_directed(8'h18, 3);
    do_reset();
    run_cycles(370);
    chk("timeout_event_count", ev_cyc.size(), 6);
    check_ev(0, 54, 0, 3, 2);  check_ev(1, 155, 0, 3, 2); check_ev(2, 256, 0, 3, 2);
    check_ev(3, 356, 1, 3, 2); check_ev(4, 358, 0, 4, 2); check_ev(5, 359, 1, 4, 0);

    // Reset while waiting on motor 3: outputs clear immediately.
    set_directed(8'h18, 3);
    do_reset();
    run_cycles(100);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_req_valid", req_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done_valid", done_valid, 0);

    // Randomized segments, each with its own traffic profile.
    for (int s = 0; s < 8; s++) begin
      case ($urandom_range(4))
        0: update_frequency_Hz = 32'd0;
        1: update_frequency_Hz = 32'd1_000_000;
        2: update_frequency_Hz = $urandom_range(8_000_000, 100_000);
        3: update_frequency_Hz = CLK;
        default: update_frequency_Hz = CLK + $urandom_range(1_000_000);
      endcase
      enable_mask = N'($urandom);
      p_ready     = $urandom_range(100, 20);
      p_resp      = $urandom_range(30, 2);
      p_wrong     = $urandom_range(30);
      p_crc_bad   = $urandom_range(50);
      p_dirty     = $urandom_range(10);
      silent      = ($urandom_range(2) == 0) ? int'($urandom_range(N - 1)) : -1;
      instant     = ($urandom_range(3) == 0);
      mask_jitter = 1'b1;
      if (s % 2 == 0) do_reset();
      run_cycles(2500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
